// File: rtl/lynx_pkg.sv
// Shared encodings for the Lynx bank/video controller: read sources, machine
// modes, wait-FSM states, I/O port addresses and register reset values.
package lynx_pkg;

  typedef enum logic [2:0] {
    SRC_FF    = 3'd0,
    SRC_ROM   = 3'd1,
    SRC_CONST = 3'd2,
    SRC_RAM   = 3'd3,
    SRC_VID   = 3'd4,
    SRC_KBD   = 3'd5,
    SRC_JOY0  = 3'd6,
    SRC_JOY1  = 3'd7
  } rd_src_e;

  typedef enum logic [1:0] {
    MODE_48K     = 2'd0,
    MODE_96K     = 2'd1,
    MODE_SCORPIO = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_GRANT = 2'd2
  } vwait_state_e;

  // Ports 80/84 are partially decoded: only a[7], a[6], a[2], a[1] matter.
  localparam logic [6:0] PORT_BANK     = 7'h7F;
  localparam logic [7:0] PORT_CTRL     = 8'h80;
  localparam logic [7:0] PORT_DAC      = 8'h84;
  localparam logic [7:0] PORT_DEC_MASK = 8'hC6;
  localparam logic [7:0] PORT_KBD      = 8'h80;
  localparam logic [6:0] PORT_JOY0     = 7'h7A;
  localparam logic [6:0] PORT_JOY1     = 7'h7B;

  localparam logic [7:0] BANK_RST = 8'h00;
  localparam logic [5:1] CTRL_RST = 5'b00110;

endpackage

// File: rtl/lynx_vwait.sv
// Video-contention wait FSM: stalls the CPU while the CRTC owns video RAM,
// bounded to WAIT_MAX ce cycles. Only instantiated when LYNX_VIDEO_WAIT_EN is set.
module lynx_vwait
  import lynx_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_acc,
  input  logic       i_de,
  input  logic       i_mreq,
  output logic       o_wait_n,
  output logic       o_go,
  output logic [1:0] o_state
);

  localparam logic [7:0] L_MAX  = 8'(WAIT_MAX);
  localparam logic [7:0] L_LAST = 8'(WAIT_MAX - 1);

  vwait_state_e r_state;
  vwait_state_e w_next;
  logic [7:0]   r_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_ce) begin
      r_state <= w_next;
      if (r_state == ST_STALL) begin
        if (r_cnt != L_MAX) r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // r_cnt holds the ce cycles already spent in STALL; leave on the last one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_acc) w_next = i_de ? ST_STALL : ST_GRANT;
      ST_STALL: if (!i_de || r_cnt >= L_LAST) w_next = ST_GRANT;
      ST_GRANT: if (i_mreq) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // A write may only strobe once the access is known not to collide with the CRTC.
  assign o_wait_n = (r_state != ST_STALL);
  assign o_go     = (r_state == ST_GRANT) || (r_state == ST_IDLE && !i_de);
  assign o_state  = r_state;

endmodule

// File: rtl/lynx_bank_ctrl.sv
// Lynx memory bank / video plane / I/O port controller.
// Define LYNX_VIDEO_WAIT_EN to add the CRTC contention wait FSM (lynx_vwait).
module lynx_bank_ctrl
  import lynx_pkg::*;
#(
  parameter int NPLANES  = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic [1:0]         i_mode,
  input  logic               i_mreq,
  input  logic               i_iorq,
  input  logic               i_wr,
  input  logic [15:0]        i_a,
  input  logic [7:0]         i_d,
  input  logic               i_de,
  input  logic               i_cas,
  output logic               o_wait_n,
  output logic               o_ram_we_n,
  output logic [15:0]        o_ram_a,
  output logic [14:0]        o_rom_a,
  output logic [NPLANES-1:0] o_vid_we_n,
  output logic [13:0]        o_vid_a,
  output logic [2:0]         o_rd_src,
  output logic [1:0]         o_rd_plane,
  output logic [5:0]         o_dac,
  output logic               o_altg,
  output logic               o_cas23,
  output logic               o_ear_sel,
  output logic [1:0]         o_dbg_state
);

  logic [7:0]         r_b;
  logic [5:1]         r_c;
  logic [5:0]         r_dac;
  logic               r_cas_q;
  logic               r_cas23;
  logic               w_io_wr;
  logic               w_wr_bank;
  logic               w_wr_ctrl;
  logic               w_wr_dac;
  logic               w_mem;
  logic               w_mode0;
  logic [3:0]         w_rd_mask;
  logic [NPLANES-1:0] w_vid_wq;
  logic               w_vid_hit;
  logic [1:0]         w_rd_plane;
  rd_src_e            w_rd_src;
  logic               w_vid_acc;
  logic               w_wait_n;
  logic               w_vid_go;
  logic [1:0]         w_state;
  logic               w_unused_bits;

  assign w_io_wr   = !i_iorq && !i_wr;
  assign w_wr_bank = w_io_wr && (i_a[6:0] == PORT_BANK);
  assign w_wr_ctrl = w_io_wr && ((i_a[7:0] & PORT_DEC_MASK) == PORT_CTRL);
  assign w_wr_dac  = w_io_wr && ((i_a[7:0] & PORT_DEC_MASK) == PORT_DAC);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_b     <= BANK_RST;
      r_c     <= CTRL_RST;
      r_dac   <= '0;
      r_cas_q <= 1'b0;
      r_cas23 <= 1'b0;
    end else if (i_ce) begin
      if (w_wr_bank) r_b   <= i_d;
      if (w_wr_ctrl) r_c   <= i_d[5:1];
      if (w_wr_dac)  r_dac <= i_d[5:0];
      r_cas_q <= i_cas;
      if (r_cas_q && !i_cas) r_cas23 <= !r_cas23;
    end
  end

  assign w_mem   = !i_mreq;
  assign w_mode0 = (i_mode == MODE_48K);
  // Planes 0/1 are masked by C[2]/C[3]; planes 2/3 alias onto B[3]/C[5].
  assign w_rd_mask = {r_c[5], r_b[3], r_c[3], r_c[2]};

  always_comb begin
    w_vid_hit  = 1'b0;
    w_rd_plane = 2'd0;
    w_vid_wq   = '0;
    for (int p = NPLANES - 1; p >= 0; p--) begin
      w_vid_wq[p] = w_mem && !i_wr && r_b[1+p] && r_c[5];
      if (!w_rd_mask[p]) begin
        w_vid_hit  = 1'b1;
        w_rd_plane = 2'(p);
      end
    end
  end

  always_comb begin
    w_rd_src = SRC_FF;
    if (w_mem && !r_b[4] && i_a[15:14] == 2'b00)                 w_rd_src = SRC_ROM;
    else if (w_mode0 && w_mem && !r_b[4] && i_a[15:13] == 3'b010) w_rd_src = SRC_CONST;
    else if (!w_mode0 && i_a[15:13] == 3'b010)                    w_rd_src = SRC_ROM;
    else if (w_mem && !r_b[5])                                     w_rd_src = SRC_RAM;
    else if (w_mem && r_b[6] && w_vid_hit)                         w_rd_src = SRC_VID;
    else if (!i_iorq && i_a[7:0] == PORT_KBD)                      w_rd_src = SRC_KBD;
    else if (!i_iorq && i_a[6:0] == PORT_JOY0)                     w_rd_src = SRC_JOY0;
    else if (i_a[6:0] == PORT_JOY1)                                w_rd_src = SRC_JOY1;
  end

  assign w_vid_acc = (w_rd_src == SRC_VID) || (|w_vid_wq);

`ifdef LYNX_VIDEO_WAIT_EN
  lynx_vwait #(
    .WAIT_MAX (WAIT_MAX)
  ) u_vwait (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_ce      (i_ce),
    .i_acc     (w_vid_acc),
    .i_de      (i_de),
    .i_mreq    (i_mreq),
    .o_wait_n  (w_wait_n),
    .o_go      (w_vid_go),
    .o_state   (w_state)
  );
`else
  logic w_unused_wait;
  assign w_wait_n      = 1'b1;
  assign w_vid_go      = 1'b1;
  assign w_state       = ST_IDLE;
  assign w_unused_wait = ^{i_de, w_vid_acc, 8'(WAIT_MAX)};
`endif

  assign w_unused_bits = ^{r_b[7], w_rd_mask};

  assign o_wait_n    = w_wait_n;
  assign o_ram_we_n  = !(w_mem && !i_wr && !r_b[0]);
  assign o_ram_a     = w_mode0 ? {2'b00, i_a[14], i_a[12:0]} : i_a;
  assign o_rom_a     = w_mode0 ? {1'b0, i_a[13:0]} : i_a[14:0];
  assign o_vid_we_n  = ~(w_vid_wq & {NPLANES{w_vid_go}});
  assign o_vid_a     = {i_a[14], i_a[12:0]};
  assign o_rd_src    = w_rd_src;
  assign o_rd_plane  = w_rd_plane;
  assign o_dac       = r_dac;
  assign o_altg      = r_c[4];
  assign o_ear_sel   = r_c[1];
  assign o_cas23     = r_cas23;
  assign o_dbg_state = w_state;

endmodule

// File: tb/tb_lynx_bank_ctrl.sv
// Directed bench for lynx_bank_ctrl; wait-FSM scenarios follow LYNX_VIDEO_WAIT_EN.
module tb_lynx_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, mreq, iorq, wr, de, cas;
  logic [1:0]  mode;
  logic [15:0] a;
  logic [7:0]  d;
  logic        o_wait_n, o_ram_we_n, o_altg, o_cas23, o_ear_sel;
  logic [15:0] o_ram_a;
  logic [14:0] o_rom_a;
  logic [2:0]  o_vid_we_n;
  logic [13:0] o_vid_a;
  logic [2:0]  o_rd_src;
  logic [1:0]  o_rd_plane, o_dbg_state;
  logic [5:0]  o_dac;
  int errors = 0;
  int checks = 0;

  lynx_bank_ctrl #(.NPLANES(3), .WAIT_MAX(15)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_ce(ce), .i_mode(mode),
    .i_mreq(mreq), .i_iorq(iorq), .i_wr(wr), .i_a(a), .i_d(d),
    .i_de(de), .i_cas(cas),
    .o_wait_n(o_wait_n), .o_ram_we_n(o_ram_we_n), .o_ram_a(o_ram_a),
    .o_rom_a(o_rom_a), .o_vid_we_n(o_vid_we_n), .o_vid_a(o_vid_a),
    .o_rd_src(o_rd_src), .o_rd_plane(o_rd_plane), .o_dac(o_dac),
    .o_altg(o_altg), .o_cas23(o_cas23), .o_ear_sel(o_ear_sel),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mreq = 1'b1; iorq = 1'b1; wr = 1'b1;
  endtask

  task automatic port_out(input logic [15:0] addr, input logic [7:0] data);
    a = addr; d = data; iorq = 1'b0; wr = 1'b0; mreq = 1'b1;
    tick();
    iorq = 1'b1; wr = 1'b1;
  endtask

  task automatic mem_start(input logic [15:0] addr, input logic wr_n);
    a = addr; mreq = 1'b0; iorq = 1'b1; wr = wr_n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n: got %b want 1", o_wait_n); end
    checks++; if (o_dac !== 6'h00) begin errors++; $display("FAIL reset_dac: got %h want 00", o_dac); end
    checks++; if (o_cas23 !== 1'b0) begin errors++; $display("FAIL reset_cas23: got %b want 0", o_cas23); end
    checks++; if ({o_altg, o_ear_sel} !== 2'b00) begin errors++; $display("FAIL reset_altg_ear: got %b want 00", {o_altg, o_ear_sel}); end
    checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_dbg_state); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ports();
    port_out(16'h007F, 8'h60);
    mem_start(16'hC000, 1'b1);
    @(negedge clk);
    checks++; if (o_rd_src !== 3'd4) begin errors++; $display("FAIL vid_rd_src: got %0d want 4", o_rd_src); end
    checks++; if (o_rd_plane !== 2'd2) begin errors++; $display("FAIL vid_rd_plane_rst: got %0d want 2", o_rd_plane); end
    tick(); bus_idle(); tick();
    port_out(16'h0080, 8'h12);
    mem_start(16'hC000, 1'b1);
    @(negedge clk);
    checks++; if ({o_altg, o_ear_sel} !== 2'b11) begin errors++; $display("FAIL ctrl_altg_ear: got %b want 11", {o_altg, o_ear_sel}); end
    checks++; if (o_rd_plane !== 2'd0) begin errors++; $display("FAIL vid_rd_plane0: got %0d want 0", o_rd_plane); end
    tick(); bus_idle(); tick();
    port_out(16'h0084, 8'h2A);
    @(negedge clk);
    checks++; if (o_dac !== 6'h2A) begin errors++; $display("FAIL dac_write: got %h want 2a", o_dac); end
    ce = 1'b0; port_out(16'h0084, 8'h15); ce = 1'b1;
    @(negedge clk);
    checks++; if (o_dac !== 6'h2A) begin errors++; $display("FAIL dac_ce_gate: got %h want 2a", o_dac); end
    port_out(16'h00B8, 8'h00);
    @(negedge clk);
    checks++; if ({o_altg, o_ear_sel} !== 2'b00) begin errors++; $display("FAIL ctrl_alias_b8: got %b want 00", {o_altg, o_ear_sel}); end
    checks++; if (o_dac !== 6'h2A) begin errors++; $display("FAIL dac_alias_b8: got %h want 2a", o_dac); end
    port_out(16'h12FF, 8'h00);
    mem_start(16'hC000, 1'b1);
    @(negedge clk);
    checks++; if (o_rd_src !== 3'd3) begin errors++; $display("FAIL bank_alias_ff: got %0d want 3", o_rd_src); end
    tick(); bus_idle(); tick();
  endtask

  task automatic test_vid_write();
    port_out(16'h007F, 8'h06);
    port_out(16'h0080, 8'h20);
    de = 1'b0; mode = 2'd0;
    mem_start(16'hC000, 1'b0);
    @(negedge clk);
    checks++; if (o_vid_we_n !== 3'b100) begin errors++; $display("FAIL vid_we_n: got %b want 100", o_vid_we_n); end
    checks++; if (o_ram_we_n !== 1'b0) begin errors++; $display("FAIL ram_we_n_b0clr: got %b want 0", o_ram_we_n); end
    checks++; if (o_vid_a !== 14'h2000) begin errors++; $display("FAIL vid_a: got %h want 2000", o_vid_a); end
    checks++; if (o_ram_a !== 16'h2000) begin errors++; $display("FAIL ram_a_48k: got %h want 2000", o_ram_a); end
    tick(); bus_idle(); tick();
    @(negedge clk);
    checks++; if (o_vid_we_n !== 3'b111) begin errors++; $display("FAIL vid_we_n_release: got %b want 111", o_vid_we_n); end
    port_out(16'h007F, 8'h07);
    mem_start(16'hC000, 1'b0);
    @(negedge clk);
    checks++; if (o_ram_we_n !== 1'b1) begin errors++; $display("FAIL ram_we_n_b0set: got %b want 1", o_ram_we_n); end
    checks++; if (o_vid_we_n !== 3'b100) begin errors++; $display("FAIL vid_we_n_b07: got %b want 100", o_vid_we_n); end
    tick(); bus_idle(); tick();
  endtask

  task automatic test_rd_src();
    logic [1:0]  t_mode [9];
    logic        t_mreq [9];
    logic        t_iorq [9];
    logic [15:0] t_a    [9];
    logic [2:0]  t_src  [9];
    t_mode = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    t_mreq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_iorq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t_a    = '{16'h4000, 16'h4000, 16'h5FFF, 16'h1234, 16'h8000,
               16'h0080, 16'h127A, 16'h00FB, 16'h0000};
    t_src  = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0};
    port_out(16'h007F, 8'h00);
    for (int i = 0; i < 9; i++) begin
      mode = t_mode[i]; mreq = t_mreq[i]; iorq = t_iorq[i]; wr = 1'b1; a = t_a[i];
      @(negedge clk);
      checks++; if (o_rd_src !== t_src[i]) begin errors++; $display("FAIL rd_src[%0d]: got %0d want %0d", i, o_rd_src, t_src[i]); end
      tick();
    end
    bus_idle();
    mem_start(16'h4000, 1'b1); mode = 2'd1;
    @(negedge clk);
    checks++; if (o_rom_a !== 15'h4000) begin errors++; $display("FAIL rom_a_96k: got %h want 4000", o_rom_a); end
    mode = 2'd0;
    @(negedge clk);
    checks++; if (o_rom_a !== 15'h0000) begin errors++; $display("FAIL rom_a_48k: got %h want 0000", o_rom_a); end
    a = 16'h7ABC; mode = 2'd2;
    @(negedge clk);
    checks++; if (o_rom_a !== 15'h7ABC) begin errors++; $display("FAIL rom_a_scorpio: got %h want 7abc", o_rom_a); end
    mode = 2'd0;
    @(negedge clk);
    checks++; if (o_rom_a !== 15'h3ABC) begin errors++; $display("FAIL rom_a_48k_hi: got %h want 3abc", o_rom_a); end
    a = 16'hC123; mode = 2'd1;
    @(negedge clk);
    checks++; if (o_ram_a !== 16'hC123) begin errors++; $display("FAIL ram_a_96k: got %h want c123", o_ram_a); end
    mode = 2'd0;
    @(negedge clk);
    checks++; if (o_ram_a !== 16'h2123) begin errors++; $display("FAIL ram_a_48k_c123: got %h want 2123", o_ram_a); end
    checks++; if (o_ram_we_n !== 1'b1) begin errors++; $display("FAIL ram_we_n_read: got %b want 1", o_ram_we_n); end
    tick(); bus_idle();
    port_out(16'h007F, 8'h10);
    mem_start(16'h0000, 1'b1);
    @(negedge clk);
    checks++; if (o_rd_src !== 3'd3) begin errors++; $display("FAIL rd_src_rom_off: got %0d want 3", o_rd_src); end
    tick(); bus_idle(); tick();
  endtask

  task automatic test_cas();
    cas = 1'b1; tick(); tick();
    @(negedge clk);
    checks++; if (o_cas23 !== 1'b0) begin errors++; $display("FAIL cas23_rise: got %b want 0", o_cas23); end
    cas = 1'b0; tick();
    @(negedge clk);
    checks++; if (o_cas23 !== 1'b1) begin errors++; $display("FAIL cas23_fall1: got %b want 1", o_cas23); end
    tick(); tick();
    @(negedge clk);
    checks++; if (o_cas23 !== 1'b1) begin errors++; $display("FAIL cas23_static: got %b want 1", o_cas23); end
    cas = 1'b1; tick(); cas = 1'b0; tick();
    @(negedge clk);
    checks++; if (o_cas23 !== 1'b0) begin errors++; $display("FAIL cas23_fall2: got %b want 0", o_cas23); end
  endtask

`ifdef LYNX_VIDEO_WAIT_EN
  task automatic test_wait_max();
    int low_cnt, first_wr, stall_wr;
    low_cnt = 0; first_wr = -1; stall_wr = 0;
    port_out(16'h007F, 8'h06); port_out(16'h0080, 8'h20);
    de = 1'b1; mem_start(16'hC000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_wait_n) low_cnt++;
      if (o_vid_we_n !== 3'b111) begin
        if (first_wr < 0) first_wr = i;
        if (!o_wait_n) stall_wr++;
      end
    end
    checks++; if (low_cnt != 15) begin errors++; $display("FAIL wait_max_len: got %0d want 15", low_cnt); end
    checks++; if (first_wr != 16) begin errors++; $display("FAIL wait_max_write_at: got %0d want 16", first_wr); end
    checks++; if (stall_wr != 0) begin errors++; $display("FAIL wait_max_stall_write: got %0d want 0", stall_wr); end
    checks++; if (o_dbg_state !== 2'd2) begin errors++; $display("FAIL wait_max_grant: got %0d want 2", o_dbg_state); end
    tick(); bus_idle(); de = 1'b0; tick();
    @(negedge clk);
    checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL wait_max_idle: got %0d want 0", o_dbg_state); end
  endtask

  task automatic test_wait_de_drop();
    int low_cnt, first_wr;
    low_cnt = 0; first_wr = -1;
    de = 1'b1; mem_start(16'hC000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!o_wait_n) low_cnt++;
      if (o_vid_we_n !== 3'b111 && first_wr < 0) first_wr = i;
      if (low_cnt == 3) de = 1'b0;
    end
    checks++; if (low_cnt != 3) begin errors++; $display("FAIL de_drop_len: got %0d want 3", low_cnt); end
    checks++; if (first_wr != 4) begin errors++; $display("FAIL de_drop_write_at: got %0d want 4", first_wr); end
    checks++; if (o_dbg_state !== 2'd2) begin errors++; $display("FAIL de_drop_grant: got %0d want 2", o_dbg_state); end
    tick(); bus_idle(); tick();
    @(negedge clk);
    checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL de_drop_idle: got %0d want 0", o_dbg_state); end
    de = 1'b1; mem_start(16'h8000, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if ({o_wait_n, o_dbg_state} !== 3'b100) begin errors++; $display("FAIL ram_no_stall: got %b want 100", {o_wait_n, o_dbg_state}); end
    tick(); bus_idle(); de = 1'b0; tick();
  endtask
`else
  task automatic test_no_wait();
    port_out(16'h007F, 8'h06); port_out(16'h0080, 8'h20);
    de = 1'b1; mem_start(16'hC000, 1'b0);
    @(negedge clk);
    checks++; if (o_vid_we_n !== 3'b100) begin errors++; $display("FAIL nowait_vid_we_n: got %b want 100", o_vid_we_n); end
    tick();
    @(negedge clk);
    checks++; if ({o_wait_n, o_dbg_state} !== 3'b100) begin errors++; $display("FAIL nowait_wait_n: got %b want 100", {o_wait_n, o_dbg_state}); end
    bus_idle(); de = 1'b0; tick();
  endtask
`endif

  task automatic test_reset_mid_stall();
    port_out(16'h007F, 8'h06); port_out(16'h0080, 8'h20);
    mode = 2'd0; de = 1'b1; mem_start(16'hC000, 1'b0);
    repeat (3) @(negedge clk);
`ifdef LYNX_VIDEO_WAIT_EN
    checks++; if ({o_wait_n, o_dbg_state} !== 3'b001) begin errors++; $display("FAIL pre_reset_stall: got %b want 001", {o_wait_n, o_dbg_state}); end
`else
    checks++; if (o_vid_we_n !== 3'b100) begin errors++; $display("FAIL pre_reset_write: got %b want 100", o_vid_we_n); end
`endif
    #1 rst_n = 1'b0;
    #1;
    checks++; if (o_wait_n !== 1'b1) begin errors++; $display("FAIL mid_reset_wait_n: got %b want 1", o_wait_n); end
    checks++; if (o_vid_we_n !== 3'b111) begin errors++; $display("FAIL mid_reset_vid_we_n: got %b want 111", o_vid_we_n); end
    checks++; if (o_rd_src !== 3'd3) begin errors++; $display("FAIL mid_reset_bank: got %0d want 3", o_rd_src); end
    checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d want 0", o_dbg_state); end
    bus_idle(); de = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    port_out(16'h007F, 8'h60);
    mem_start(16'hC000, 1'b1);
    @(negedge clk);
    checks++; if ({o_rd_src, o_rd_plane} !== {3'd4, 2'd2}) begin errors++; $display("FAIL post_reset_ctrl: got %0d/%0d want 4/2", o_rd_src, o_rd_plane); end
    checks++; if ({o_altg, o_ear_sel} !== 2'b00) begin errors++; $display("FAIL post_reset_altg_ear: got %b want 00", {o_altg, o_ear_sel}); end
    tick(); bus_idle(); tick();
  endtask

  initial begin
    ce = 1'b1; mode = 2'd0; de = 1'b0; cas = 1'b0; a = '0; d = '0;
    bus_idle();
    test_reset();
    test_ports();
    test_vid_write();
    test_rd_src();
    test_cas();
`ifdef LYNX_VIDEO_WAIT_EN
    test_wait_max();
    test_wait_de_drop();
`else
    test_no_wait();
`endif
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
